// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcode/funct codes,
// controller states and instruction field positions.
package mips_pkg;

    // Instruction field bit positions (independent of XLEN)
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int TGT_LSB = 0;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/mips_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous
// write port. Register 0 always reads zero and ignores writes.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_reg [32];

    // Clear every register on reset; otherwise write any register except $0
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_reg[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_reg[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core with req/ack instruction and data ports.
// Optional build macro MIPS_MC_PERF_EN adds cycle/retire counters.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                 XLEN     = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_out
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retire_cnt
`endif
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [31:0]       ir_reg, ir_next;
    logic [XLEN-1:0]   a_reg, a_next, b_reg, b_next, imm_reg, imm_next;
    logic [XLEN-1:0]   alu_reg, alu_next, mdr_reg, mdr_next;
    logic              imem_req_reg, imem_req_next;
    logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
    logic              dmem_req_reg, dmem_req_next, dmem_we_reg, dmem_we_next;
    logic [ADDR_W-1:0] dmem_addr_reg, dmem_addr_next;
    logic [XLEN-1:0]   dmem_wdata_reg, dmem_wdata_next;
    logic              illegal_reg, illegal_next;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata, rf_rdata_a, rf_rdata_b;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [ADDR_W-1:0] pc_inc, br_tgt;
    logic [XLEN-1:0]   eff_addr;

    assign opcode   = ir_reg[OP_MSB:OP_LSB];
    assign rs       = ir_reg[RS_MSB:RS_LSB];
    assign rt       = ir_reg[RT_MSB:RT_LSB];
    assign rd       = ir_reg[RD_MSB:RD_LSB];
    assign shamt    = ir_reg[SH_MSB:SH_LSB];
    assign funct    = ir_reg[FN_MSB:FN_LSB];
    assign pc_inc   = pc_reg + ADDR_W'(1);
    assign br_tgt   = pc_inc + ADDR_W'($signed(ir_reg[IMM_MSB:IMM_LSB]));
    assign eff_addr = a_reg + imm_reg;

    mips_regfile #(.XLEN(XLEN)) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    // Controller state and datapath registers; reset abandons any transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            imm_reg        <= '0;
            alu_reg        <= '0;
            mdr_reg        <= '0;
            imem_req_reg   <= 1'b0;
            imem_addr_reg  <= '0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ir_reg         <= ir_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            imm_reg        <= imm_next;
            alu_reg        <= alu_next;
            mdr_reg        <= mdr_next;
            imem_req_reg   <= imem_req_next;
            imem_addr_reg  <= imem_addr_next;
            dmem_req_reg   <= dmem_req_next;
            dmem_we_reg    <= dmem_we_next;
            dmem_addr_reg  <= dmem_addr_next;
            dmem_wdata_reg <= dmem_wdata_next;
            illegal_reg    <= illegal_next;
        end
    end

    // Next-state, ALU and bus-request logic; a request is raised on the
    // same edge that enters FETCH/MEM so zero-wait memory costs one cycle
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ir_next         = ir_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        imm_next        = imm_reg;
        alu_next        = alu_reg;
        mdr_next        = mdr_reg;
        imem_req_next   = imem_req_reg;
        imem_addr_next  = imem_addr_reg;
        dmem_req_next   = dmem_req_reg;
        dmem_we_next    = dmem_we_reg;
        dmem_addr_next  = dmem_addr_reg;
        dmem_wdata_next = dmem_wdata_reg;
        illegal_next    = illegal_reg;
        rf_we           = 1'b0;
        rf_waddr        = (opcode == OP_RTYPE) ? rd : rt;
        rf_wdata        = (opcode == OP_LW) ? mdr_reg : alu_reg;

        case (state_reg)
            FETCH: begin
                if (!imem_req_reg) begin
                    // first fetch after reset
                    imem_req_next  = 1'b1;
                    imem_addr_next = pc_reg;
                end else if (imem_ack) begin
                    imem_req_next = 1'b0;
                    ir_next       = imem_rdata;
                    state_next    = DECODE;
                end
            end
            DECODE: begin
                a_next     = rf_rdata_a;
                b_next     = rf_rdata_b;
                imm_next   = XLEN'($signed(ir_reg[IMM_MSB:IMM_LSB]));
                state_next = EXEC;
            end
            EXEC: begin
                state_next = WB;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD: alu_next = a_reg + b_reg;
                            FN_SUB: alu_next = a_reg - b_reg;
                            FN_AND: alu_next = a_reg & b_reg;
                            FN_OR:  alu_next = a_reg | b_reg;
                            FN_SLT: alu_next = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
                            FN_SLL: alu_next = b_reg << shamt;
                            FN_SRL: alu_next = b_reg >> shamt;
                            FN_JR: begin
                                pc_next    = ADDR_W'(a_reg);
                                state_next = FETCH;
                            end
                            default: begin
                                illegal_next = 1'b1;
                                state_next   = HALT;
                            end
                        endcase
                    end
                    OP_ADDI: alu_next = eff_addr;
                    OP_LW, OP_SW: begin
                        dmem_req_next  = 1'b1;
                        dmem_we_next   = (opcode == OP_SW);
                        dmem_addr_next = ADDR_W'(eff_addr);
                        if (opcode == OP_SW) begin
                            dmem_wdata_next = b_reg;
                        end
                        state_next = MEM;
                    end
                    OP_BEQ: begin
                        pc_next    = (a_reg == b_reg) ? br_tgt : pc_inc;
                        state_next = FETCH;
                    end
                    OP_BNE: begin
                        pc_next    = (a_reg != b_reg) ? br_tgt : pc_inc;
                        state_next = FETCH;
                    end
                    OP_J: begin
                        pc_next    = ADDR_W'(ir_reg[TGT_MSB:TGT_LSB]);
                        state_next = FETCH;
                    end
                    OP_HALT: state_next = HALT;
                    default: begin
                        illegal_next = 1'b1;
                        state_next   = HALT;
                    end
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    dmem_req_next = 1'b0;
                    dmem_we_next  = 1'b0;
                    if (dmem_we_reg) begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end else begin
                        mdr_next   = dmem_rdata;
                        state_next = WB;
                    end
                end
            end
            WB: begin
                rf_we      = 1'b1;
                pc_next    = pc_inc;
                state_next = FETCH;
            end
            default: ; // HALT: everything frozen until reset
        endcase

        // Entering FETCH from a completed instruction starts the next fetch
        if ((state_next == FETCH) && (state_reg != FETCH)) begin
            imem_req_next  = 1'b1;
            imem_addr_next = pc_next;
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = imem_addr_reg;
    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign halted     = (state_reg == HALT);
    assign illegal    = illegal_reg;
    assign pc_out     = pc_reg;

`ifdef MIPS_MC_PERF_EN
    logic retire_evt;
    assign retire_evt = (state_reg == WB) ||
                        ((state_reg == MEM) && (state_next == FETCH)) ||
                        ((state_reg == EXEC) && ((state_next == FETCH) ||
                         ((state_next == HALT) && !illegal_next)));

    // Free-running activity counters, both wrap
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state_reg != HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire_evt) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: ALU vector table, memory
// handshake, branch/jump, halt/illegal and reset-abort sequences.
module tb_mips_multicycle_core;
    import mips_pkg::*;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        halted;
    logic        illegal;
    logic [31:0] pc_out;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
`endif

    mips_multicycle_core #(.XLEN(32), .ADDR_W(32), .RESET_PC(32'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .illegal    (illegal),
        .pc_out     (pc_out)
`ifdef MIPS_MC_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] imem [512];
    logic [31:0] dmem_init [64];
    logic [31:0] dwr [64];
    logic        dwr_valid [64];
    int          dmem_delay = 0;
    int          dwait = 0;

    assign imem_ack   = imem_req;
    assign imem_rdata = imem[imem_addr[8:0]];
    assign dmem_ack   = dmem_req && (dwait >= dmem_delay);
    assign dmem_rdata = dwr_valid[dmem_addr[5:0]] ? dwr[dmem_addr[5:0]] : dmem_init[dmem_addr[5:0]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fetch_q[$];
    int          fcyc_q[$];
    int          dlen_q[$];
    int          cyc = 0;
    int          drun = 0;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_we;
    logic        dstable_err = 1'b0;

    // Memory responder, fetch log and store scoreboard
    always @(posedge clock) begin
        wr_t e;
        cyc <= cyc + 1;
        if (reset) begin
            for (int i = 0; i < 64; i++) dwr_valid[i] <= 1'b0;
        end
        if (imem_req && imem_ack && !reset) begin
            fetch_q.push_back(imem_addr);
            fcyc_q.push_back(cyc);
        end
        dwait <= (dmem_req && !dmem_ack) ? dwait + 1 : 0;
        if (dmem_req && !reset) begin
            if (drun == 0) begin
                snap_addr  <= dmem_addr;
                snap_wdata <= dmem_wdata;
                snap_we    <= dmem_we;
            end else if (dmem_addr !== snap_addr || dmem_we !== snap_we ||
                         (dmem_we && dmem_wdata !== snap_wdata)) begin
                dstable_err <= 1'b1;
            end
            if (dmem_ack) begin
                dlen_q.push_back(drun + 1);
                drun <= 0;
            end else begin
                drun <= drun + 1;
            end
        end
        if (dmem_req && dmem_ack && dmem_we && !reset) begin
            dwr[dmem_addr[5:0]]       <= dmem_wdata;
            dwr_valid[dmem_addr[5:0]] <= 1'b1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_store: got addr %h data %h, required no store", dmem_addr, dmem_wdata);
            end else begin
                e = exp_q.pop_front();
                $display("store addr=%0h data=%h", dmem_addr, dmem_wdata);
                check("store_addr", dmem_addr, e.addr);
                check("store_data", dmem_wdata, e.data);
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input int tgt);
        return {op, 26'(tgt)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 512; i++) imem[i] = {OP_HALT, 26'd0};
    endtask

    task automatic start_prog();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        fetch_q.delete();
        fcyc_q.delete();
        dlen_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int max_cyc);
        for (int i = 0; i < max_cyc && !halted; i++) @(negedge clock);
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        string       name;
        logic [5:0]  funct;
        int          shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs[10];

    initial begin
        int req_cnt;
        vecs[0] = '{"add",      FN_ADD, 0,  32'd7,        32'd5,        32'd12};
        vecs[1] = '{"add_wrap", FN_ADD, 0,  32'hFFFFFFFF, 32'd1,        32'd0};
        vecs[2] = '{"sub_neg",  FN_SUB, 0,  32'd3,        32'd5,        32'hFFFFFFFE};
        vecs[3] = '{"and",      FN_AND, 0,  32'hF0F0FFFF, 32'h0FF000FF, 32'h00F000FF};
        vecs[4] = '{"or",       FN_OR,  0,  32'hF0000000, 32'h0000000F, 32'hF000000F};
        vecs[5] = '{"slt_m1_1", FN_SLT, 0,  32'hFFFFFFFF, 32'd1,        32'd1};
        vecs[6] = '{"slt_1_m1", FN_SLT, 0,  32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[7] = '{"sll_31",   FN_SLL, 31, 32'd0,        32'd1,        32'h80000000};
        vecs[8] = '{"srl_31",   FN_SRL, 31, 32'd0,        32'h80000000, 32'd1};
        vecs[9] = '{"srl_4",    FN_SRL, 4,  32'd0,        32'hF0000000, 32'h0F000000};

        reset = 1'b1;
        for (int i = 0; i < 64; i++) dmem_init[i] = 32'd0;
        clear_imem();
        repeat (3) @(negedge clock);

        // reset state
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);

        // table-driven ALU ops: load operands, operate, store result
        for (int v = 0; v < 10; v++) begin
            clear_imem();
            imem[0] = enc_i(OP_LW, 0, 1, 0);
            imem[1] = enc_i(OP_LW, 0, 2, 1);
            imem[2] = enc_r(1, 2, 3, vecs[v].shamt, vecs[v].funct);
            imem[3] = enc_i(OP_SW, 0, 3, 2);
            dmem_init[0] = vecs[v].a;
            dmem_init[1] = vecs[v].b;
            exp_q.push_back('{32'd2, vecs[v].exp});
            start_prog();
            wait_halt(200);
            $display("vector %s a=%h b=%h expected %h", vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].exp);
            check("alu_illegal", {31'd0, illegal}, 32'd0);
            check("alu_halt_pc", pc_out, 32'd4);
            check("alu_sb_empty", exp_q.size(), 32'd0);
        end

        // addi/add sequence, $0 discard, lw, cycle counts (zero wait)
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_ADDI, 0, 2, -3);
        imem[2] = enc_r(1, 2, 3, 0, FN_ADD);
        imem[3] = enc_i(OP_SW, 0, 3, 0);
        imem[4] = enc_i(OP_ADDI, 0, 0, 9);
        imem[5] = enc_r(0, 0, 5, 0, FN_ADD);
        imem[6] = enc_i(OP_SW, 0, 5, 1);
        imem[7] = enc_i(OP_LW, 0, 6, 0);
        imem[8] = enc_i(OP_SW, 0, 6, 3);
        exp_q.push_back('{32'd0, 32'd2});
        exp_q.push_back('{32'd1, 32'd0});
        exp_q.push_back('{32'd3, 32'd2});
        start_prog();
        wait_halt(200);
        $display("sequence addi/add/lw: %0d fetches", fetch_q.size());
        check("seq_fetches", fetch_q.size(), 32'd10);
        check("seq_cycles_3instr", fcyc_q[3] - fcyc_q[0], 32'd12);
        check("seq_sw_cycles", fcyc_q[4] - fcyc_q[3], 32'd4);
        check("seq_lw_cycles", fcyc_q[8] - fcyc_q[7], 32'd5);
        check("seq_sb_empty", exp_q.size(), 32'd0);

        // delayed data memory: sw held 4 cycles, then lw reads it back
        dmem_delay = 3;
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 0, 1, 5);
        imem[1] = enc_i(OP_SW, 0, 1, 4);
        imem[2] = enc_i(OP_LW, 0, 4, 4);
        imem[3] = enc_i(OP_SW, 0, 4, 5);
        exp_q.push_back('{32'd4, 32'd5});
        exp_q.push_back('{32'd5, 32'd5});
        start_prog();
        wait_halt(200);
        $display("delayed memory: %0d data transfers", dlen_q.size());
        check("dly_sw_req_len", dlen_q[0], 32'd4);
        check("dly_xfer_count", dlen_q.size(), 32'd3);
        check("dly_sb_empty", exp_q.size(), 32'd0);
        dmem_delay = 0;

        // branches and jump
        clear_imem();
        imem[0]  = enc_i(OP_ADDI, 0, 1, 7);
        imem[1]  = enc_i(OP_BNE, 0, 0, 7);
        imem[2]  = enc_j(OP_J, 10);
        imem[10] = enc_i(OP_BEQ, 0, 0, -1);
        start_prog();
        for (int i = 0; i < 100 && fetch_q.size() < 6; i++) @(negedge clock);
        $display("branch fetch order: %0h %0h %0h %0h %0h %0h", fetch_q[0], fetch_q[1], fetch_q[2], fetch_q[3], fetch_q[4], fetch_q[5]);
        check("br_bne_not_taken", fetch_q[2], 32'd2);
        check("br_j_target", fetch_q[3], 32'd10);
        check("br_beq_self", fetch_q[4], 32'd10);
        check("br_beq_again", fetch_q[5], 32'd10);
        check("br_cycles", fcyc_q[2] - fcyc_q[1], 32'd3);
        check("br_not_halted", {31'd0, halted}, 32'd0);

        // reset coincident with a fetch handshake
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clock);
        check("abort_req_seen", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        clear_imem();
        imem[0] = enc_i(OP_SW, 0, 1, 0);
        imem[1] = enc_j(OP_J, 32'h100);
        exp_q.push_back('{32'd0, 32'd0});
        @(negedge clock);
        check("abort_req_low", {31'd0, imem_req}, 32'd0);
        check("abort_pc", pc_out, 32'd0);
        fetch_q.delete();
        fcyc_q.delete();
        reset = 1'b0;
        wait_halt(100);
        $display("after abort: first fetch %0h, jump fetch %0h", fetch_q[0], fetch_q[2]);
        check("abort_restart_pc", fetch_q[0], 32'd0);
        check("j_0x100", fetch_q[2], 32'h100);
        check("j_halt_pc", pc_out, 32'h100);
        check("abort_sb_empty", exp_q.size(), 32'd0);

        // halt opcode: no further fetches
        clear_imem();
        start_prog();
        wait_halt(50);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (imem_req) req_cnt++;
        end
        $display("halt: illegal=%0d pc=%0h", illegal, pc_out);
        check("halt_illegal", {31'd0, illegal}, 32'd0);
        check("halt_no_fetch", req_cnt, 32'd0);
        check("halt_fetches", fetch_q.size(), 32'd1);
        check("halt_pc", pc_out, 32'd0);

        // undefined opcode
        clear_imem();
        imem[0] = {6'h3E, 26'd0};
        start_prog();
        wait_halt(50);
        $display("opcode 3e: illegal=%0d", illegal);
        check("ill_op", {31'd0, illegal}, 32'd1);

        // undefined funct
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 0, 1, 1);
        imem[1] = enc_r(1, 1, 2, 0, 6'h3F);
        start_prog();
        wait_halt(50);
        $display("funct 3f: illegal=%0d pc=%0h", illegal, pc_out);
        check("ill_funct", {31'd0, illegal}, 32'd1);
        check("ill_pc", pc_out, 32'd1);

        check("dmem_stable", {31'd0, dstable_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width (>=32).
REQ-002 Parameter ADDR_W, default 32, word-address width of both memory ports.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 imem_req  out  1  instruction fetch request; imem_addr  out  ADDR_W  fetch word address.
REQ-007 imem_ack  in  1  fetch complete; imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-008 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  ADDR_W; dmem_wdata  out  XLEN.
REQ-009 dmem_ack  in  1; dmem_rdata  in  XLEN, valid when dmem_ack=1 and dmem_we=0.
REQ-010 halted  out  1  core stopped; illegal  out  1  stop caused by undefined opcode/funct; pc_out  out  ADDR_W  current PC.

Function
REQ-011 States: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except FETCH/MEM, which hold until ack.
REQ-012 Handshake: req held high with addr/wdata/we stable until sampled ack=1; transfer completes on the same edge; req low the following cycle; ack while req=0 ignored.
REQ-013 FETCH -> DECODE on imem_ack (instruction latched); DECODE reads rs/rt and sign-extends imm16 to XLEN -> EXEC.
REQ-014 Supported: R-type add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02, jr 0x08; addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, halt 0x3F.
REQ-015 Arithmetic modulo 2^XLEN, no overflow trap; shifts use shamt[4:0], zero-fill.
REQ-016 PC is word-addressed; default next PC = PC+1, wraps modulo 2^ADDR_W.
REQ-017 EXEC: beq/bne taken -> PC = PC+1+sext(imm); j -> PC = zero-extended address[25:0] truncated to ADDR_W; jr -> PC = rs[ADDR_W-1:0]; all three then -> FETCH.
REQ-018 EXEC: lw/sw -> MEM with dmem_addr = (rs+sext(imm))[ADDR_W-1:0]; sw writes rt; R-type/addi -> WB.
REQ-019 MEM: sw -> FETCH on dmem_ack; lw latches dmem_rdata -> WB.
REQ-020 WB writes rd (R-type) or rt (addi/lw), PC += 1, -> FETCH.
REQ-021 Register 0 reads zero; writes to it discarded.
REQ-022 Zero-wait memory cycle counts: R-type/addi 4, lw 5, sw 4, branch/jump 3.
REQ-023 halt opcode -> HALT with halted=1, illegal=0; undefined opcode/funct -> HALT with halted=1, illegal=1; PC frozen; HALT exits only by reset.

Reset
REQ-024 On reset: state FETCH, PC=RESET_PC, all registers 0, imem_req=dmem_req=dmem_we=0, halted=illegal=0, addresses/wdata 0.
REQ-025 Reset mid-transaction abandons it: req low next cycle, any coincident ack ignored, no register or PC update from the aborted instruction.

Configuration
REQ-026 Macro MIPS_MC_PERF_EN: when defined, adds outputs cycle_cnt (32) and retire_cnt (32), cleared on reset, cycle_cnt +1 every non-HALT cycle, retire_cnt +1 per completed instruction (halt counts), both wrap; when undefined, ports and counters absent, other behaviour identical.

Structure
REQ-027 Package mips_pkg holds opcode/funct constants, state enum and XLEN-independent instruction field positions.
REQ-028 Sub-module mips_regfile: 32 x XLEN, two combinational read ports, one synchronous write port, register 0 hardwired zero; ALU and FSM stay in the core.

Verification
REQ-029 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> $3=2, total 12 cycles with zero-wait memory.
REQ-030 sw $1,4($0) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, addr=4, wdata=5 stable; lw $4,4($0) -> $4=5.
REQ-031 beq $0,$0,-1 at PC=10 -> next fetch address 10; bne $0,$0,+7 -> next fetch 11; j 0x100 -> fetch 0x100.
REQ-032 addi $0,$0,9 then add $5,$0,$0 -> $5=0; slt with -1 vs 1 -> 1.
REQ-033 Opcode 0x3F -> halted=1, illegal=0, no further imem_req; opcode 0x3E -> halted=1, illegal=1.
REQ-034 Reset asserted during held imem_req with ack arriving same cycle -> next cycle imem_req=0, then fetch restarts at RESET_PC, registers 0.
